board_wport_arbiter: RTL

// - Owns the single write port of the Life board RAM; grants it to three requesters: user cell edit, full-board fill (clear/random), evolve-engine next-generation writeback.
// - Sequences fill as an internal row-major sweep with an on-chip LFSR for random fill.
// - Gates requesters by mode: edit/fill in edit mode (mode=0), evolve in run mode (mode=1).

---
 rtl/board_wport_arbiter_if.sv | 33 +++
 rtl/board_wport_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/board_wport_arbiter_if.sv
// board_wport_arbiter_if: requester handshakes and board RAM write port of the board write arbiter
interface board_wport_arbiter_if #(parameter int K = 6);
    logic         mode;
    logic         edit_req;
    logic [K-1:0] edit_x;
    logic [K-1:0] edit_y;
    logic         edit_data;
    logic         edit_gnt;
    logic         fill_req;
    logic         fill_kind;
    logic         fill_busy;
    logic         fill_done;
    logic         evo_valid;
    logic [K-1:0] evo_x;
    logic [K-1:0] evo_y;
    logic         evo_data;
    logic         evo_ready;
    logic         we;
    logic [K-1:0] waddr_c;
    logic [K-1:0] waddr_r;
    logic         wdata;
    logic [1:0]   owner;
    modport master (
        output mode, edit_req, edit_x, edit_y, edit_data, fill_req, fill_kind,
               evo_valid, evo_x, evo_y, evo_data,
        input  edit_gnt, fill_busy, fill_done, evo_ready, we, waddr_c, waddr_r, wdata, owner
    );
    modport slave (
        input  mode, edit_req, edit_x, edit_y, edit_data, fill_req, fill_kind,
               evo_valid, evo_x, evo_y, evo_data,
        output edit_gnt, fill_busy, fill_done, evo_ready, we, waddr_c, waddr_r, wdata, owner
    );
endinterface

// File: rtl/board_wport_arbiter.sv
// board_wport_arbiter: grants the single board RAM write port to cell edit, board fill or evolve writeback
module board_wport_arbiter #(
    parameter int          K    = 6,
    parameter logic [15:0] SEED = 16'd825
) (
    input logic                  clk,
    input logic                  rst,
    board_wport_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EDIT, FILL, EVOLVE} state_t;
    state_t         state;
    logic           kind;
    logic [2*K-1:0] cnt;
    logic [15:0]    lfsr;
    logic [15:0]    lfsr_step;
    logic           fill_k;
    logic           do_fill;
    logic           accept;
    always_comb begin
        fill_k    = (state == IDLE) ? bus.fill_kind : kind;
        lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        do_fill   = (state == IDLE && !bus.mode && bus.fill_req) || (state == FILL && !bus.fill_done);
        accept    = bus.evo_valid & bus.evo_ready;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            kind          <= 1'b0;
            cnt           <= '0;
            lfsr          <= SEED;
            bus.we        <= 1'b0;
            bus.waddr_c   <= '0;
            bus.waddr_r   <= '0;
            bus.wdata     <= 1'b0;
            bus.edit_gnt  <= 1'b0;
            bus.fill_busy <= 1'b0;
            bus.fill_done <= 1'b0;
            bus.evo_ready <= 1'b0;
            bus.owner     <= 2'd0;
        end else begin
            bus.we        <= 1'b0;
            bus.edit_gnt  <= 1'b0;
            bus.fill_busy <= 1'b0;
            bus.fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mode) begin
                        state         <= EVOLVE;
                        bus.owner     <= 2'd3;
                        bus.evo_ready <= 1'b1;
                    end else if (bus.fill_req) begin
                        state     <= FILL;
                        kind      <= bus.fill_kind;
                        bus.owner <= 2'd2;
                    end else if (bus.edit_req) begin
                        state        <= EDIT;
                        bus.owner    <= 2'd1;
                        bus.we       <= 1'b1;
                        bus.edit_gnt <= 1'b1;
                        bus.waddr_c  <= bus.edit_x;
                        bus.waddr_r  <= bus.edit_y;
                        bus.wdata    <= bus.edit_data;
                    end
                end
                EDIT: begin
                    state     <= IDLE;
                    bus.owner <= 2'd0;
                end
                FILL: begin
                    // the registered done flag marks the last write just issued
                    if (bus.fill_done) begin
                        state     <= IDLE;
                        bus.owner <= 2'd0;
                    end
                end
                EVOLVE: begin
                    if (accept) begin
                        bus.we      <= 1'b1;
                        bus.waddr_c <= bus.evo_x;
                        bus.waddr_r <= bus.evo_y;
                        bus.wdata   <= bus.evo_data;
                    end
                    if (!bus.mode) begin
                        state         <= IDLE;
                        bus.owner     <= 2'd0;
                        bus.evo_ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (do_fill) begin
                bus.we        <= 1'b1;
                bus.fill_busy <= 1'b1;
                bus.waddr_r   <= cnt[2*K-1:K];
                bus.waddr_c   <= cnt[K-1:0];
                bus.wdata     <= fill_k & lfsr[0];
                bus.fill_done <= &cnt;
                cnt           <= cnt + 1'b1;
                if (fill_k) lfsr <= lfsr_step;
            end
        end
    end
endmodule
